mem_stage: RTL and testbench

Memory-access stage sitting directly downstream of the EX/MEM pipeline register and feeding write-back. It issues loads and stores to data memory over a req/ack handshake and stalls the upstream pipeline until the access completes. It aligns and extends load data, detects misaligned accesses, and holds the MEM/WB pipeline register.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_stage_if.sv | 13 +
 rtl/mem_load_align.sv | 28 ++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: control-word bits, access sizes,
// exception vectors, FSM states and the MEM/WB register layout.
package mem_pkg;
  localparam int CTL_BUBBLE   = 0;
  localparam int CTL_REGWRITE = 1;
  localparam int CTL_MEMREAD  = 2;
  localparam int CTL_MEMWRITE = 3;
  localparam int CTL_SIZE_LO  = 4;
  localparam int CTL_UNSIGNED = 6;
  localparam int CTL_MEMTOREG = 7;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] EXC_STORE_MISALIGN = 5'd5;

  localparam logic [7:0] BUBBLE_CTRL = 8'h01;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [31:0] data;
    logic [4:0]  regdst;
    logic [4:0]  vector;
    logic [31:0] pc;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '{BUBBLE_CTRL, 32'h0, 5'h0, 5'h0, 32'h0};
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_load_align.sv
// Little-endian load lane select plus sign/zero extension.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: data = {{24{~zext & b[7]}}, b};
      SIZE_HALF: data = {{16{~zext & h[15]}}, h};
      default:   data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls upstream until ack,
// flags misaligned accesses and holds the MEM/WB pipeline register.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  control_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] sw_in,
  input  logic [4:0]  regdst_in,
  input  logic [4:0]  vector_ex_in,
  input  logic [31:0] pc_in,
  input  logic        mem_flush,
  output logic        mem_stall,
  mem_stage_if.master dmem,
  output logic [7:0]  control_out,
  output logic [31:0] data_out,
  output logic [4:0]  regdst_out,
  output logic [4:0]  vector_out,
  output logic [31:0] pc_out
);
  state_e      state;
  logic        kill;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  memwb_t      wb, wb_nxt, instr;

  logic [1:0]  size;
  logic        is_mem, live, misaligned, mem_op;
  logic [4:0]  vec;
  logic [31:0] wdata_nxt, load_data;
  logic [3:0]  be_nxt;

  assign size       = control_in[CTL_SIZE_LO +: 2];
  assign is_mem     = control_in[CTL_MEMREAD] | control_in[CTL_MEMWRITE];
  assign live       = ~control_in[CTL_BUBBLE];
  assign misaligned = is_mem && ((size == SIZE_HALF && alu_in[0]) ||
                                 (size == SIZE_WORD && alu_in[1:0] != 2'b00));
  assign mem_op     = live && is_mem && vector_ex_in == 5'd0 && !misaligned && !mem_flush;
  // Deliberately independent of rdata so the stall path stays short.
  assign mem_stall  = (state == IDLE && mem_op) || (state == BUSY && !dmem.ack);

  // Upstream vectors win; a load+store word flags as a load.
  assign vec = (vector_ex_in != 5'd0) ? vector_ex_in :
               !misaligned            ? 5'd0 :
               control_in[CTL_MEMREAD] ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;

  always_comb begin
    case (size)
      SIZE_BYTE: begin
        wdata_nxt = {4{sw_in[7:0]}};
        be_nxt    = 4'b0001 << alu_in[1:0];
      end
      SIZE_HALF: begin
        wdata_nxt = {2{sw_in[15:0]}};
        be_nxt    = alu_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_nxt = sw_in;
        be_nxt    = 4'b1111;
      end
    endcase
  end

  mem_load_align u_align (
    .rdata (dmem.rdata),
    .addr  (alu_in[1:0]),
    .size  (size),
    .zext  (control_in[CTL_UNSIGNED]),
    .data  (load_data)
  );

  always_comb begin
    instr = '{control_in, alu_in, regdst_in, vec, pc_in};
    // Load data only exists on the ack cycle of a real access.
    if (state == BUSY && control_in[CTL_MEMTOREG]) instr.data = load_data;
    wb_nxt = wb;
    if (state == IDLE) begin
      wb_nxt = (mem_op || mem_flush || !live) ? MEMWB_BUBBLE : instr;
    end else if (dmem.ack) begin
      wb_nxt = (kill || mem_flush) ? MEMWB_BUBBLE : instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      kill    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      wb      <= MEMWB_BUBBLE;
    end else begin
      wb <= wb_nxt;
      if (state == IDLE) begin
        if (mem_op) begin
          state   <= BUSY;
          req_q   <= 1'b1;
          we_q    <= control_in[CTL_MEMWRITE];
          addr_q  <= {alu_in[31:2], 2'b00};
          wdata_q <= wdata_nxt;
          be_q    <= be_nxt;
          kill    <= 1'b0;
        end
      end else if (dmem.ack) begin
        state <= IDLE;
        req_q <= 1'b0;
        kill  <= 1'b0;
      end else if (mem_flush) begin
        kill <= 1'b1;
      end
    end
  end

  assign dmem.req    = req_q;
  assign dmem.we     = we_q;
  assign dmem.addr   = addr_q;
  assign dmem.wdata  = wdata_q;
  assign dmem.be     = be_q;

  assign control_out = wb.ctrl;
  assign data_out    = wb.data;
  assign regdst_out  = wb.regdst;
  assign vector_out  = wb.vector;
  assign pc_out      = wb.pc;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change on the falling edge, outputs are
// sampled on the falling edge (registered) or 1ns after a drive (mem_stall).
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  control_in;
  logic [31:0] alu_in, sw_in, pc_in;
  logic [4:0]  regdst_in, vector_ex_in;
  logic        mem_flush;
  logic        mem_stall;
  logic [7:0]  control_out;
  logic [31:0] data_out, pc_out;
  logic [4:0]  regdst_out, vector_out;
  int          errs = 0;
  int          checks = 0;
  int          cnt;

  mem_stage_if bus ();

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .control_in   (control_in),
    .alu_in       (alu_in),
    .sw_in        (sw_in),
    .regdst_in    (regdst_in),
    .vector_ex_in (vector_ex_in),
    .pc_in        (pc_in),
    .mem_flush    (mem_flush),
    .mem_stall    (mem_stall),
    .dmem         (bus),
    .control_out  (control_out),
    .data_out     (data_out),
    .regdst_out   (regdst_out),
    .vector_out   (vector_out),
    .pc_out       (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [31:0] a, input logic [31:0] s,
                       input logic [4:0] rd, input logic [4:0] v, input logic [31:0] p);
    control_in = c; alu_in = a; sw_in = s; regdst_in = rd; vector_ex_in = v; pc_in = p;
    #1;
  endtask

  task automatic bubble();
    drive(8'h01, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0);
  endtask

  initial begin
    mem_flush = 1'b0; bus.ack = 1'b0; bus.rdata = 32'h0;
    bubble();
    #1 reset = 1'b0;
    #2;
    check("rst_ctrl", control_out, 32'h01);
    check("rst_data", data_out, 32'h0);
    check("rst_req", bus.req, 32'h0);
    check("rst_be", bus.be, 32'h0);
    check("rst_stall", mem_stall, 32'h0);
    @(negedge clk); reset = 1'b1;

    // back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      drive(8'h02, 32'h100 + i, 32'h0, 5'd3 + 5'(i), 5'd0, 32'h40 + 4 * i);
      check("alu_stall", mem_stall, 32'h0);
      @(negedge clk);
      check("alu_data", data_out, 32'h100 + i);
      check("alu_ctrl", control_out, 32'h02);
      check("alu_rd", regdst_out, 32'd3 + i);
      check("alu_pc", pc_out, 32'h40 + 4 * i);
    end

    // signed byte load, ack on the fourth cycle after issue
    drive(8'hA6, 32'h1003, 32'h0, 5'd7, 5'd0, 32'h80);
    bus.rdata = 32'h80FF_FF00;
    cnt = 0;
    if (mem_stall) cnt++;
    @(negedge clk);
    check("lb_req", bus.req, 32'h1);
    check("lb_addr", bus.addr, 32'h1000);
    check("lb_we", bus.we, 32'h0);
    check("lb_issue_bubble", control_out, 32'h01);
    repeat (3) begin
      if (mem_stall) cnt++;
      @(negedge clk);
      check("lb_hold_req", bus.req, 32'h1);
    end
    bus.ack = 1'b1; #1;
    check("lb_ack_stall", mem_stall, 32'h0);
    check("lb_stall_cycles", cnt, 32'd4);
    @(negedge clk);
    bus.ack = 1'b0;
    check("lb_data", data_out, 32'hFFFF_FF80);
    check("lb_ctrl", control_out, 32'hA6);
    check("lb_rd", regdst_out, 32'd7);
    check("lb_req_clr", bus.req, 32'h0);
    bubble();

    // half store in upper lane
    drive(8'h18, 32'h2002, 32'h0000_BEEF, 5'd0, 5'd0, 32'h90);
    check("sh_stall", mem_stall, 32'h1);
    @(negedge clk);
    check("sh_addr", bus.addr, 32'h2000);
    check("sh_be", bus.be, 32'hC);
    check("sh_wdata", bus.wdata, 32'hBEEF_BEEF);
    check("sh_we", bus.we, 32'h1);
    bus.ack = 1'b1; #1;
    check("sh_ack_stall", mem_stall, 32'h0);
    @(negedge clk);
    bus.ack = 1'b0;
    check("sh_ctrl", control_out, 32'h18);
    check("sh_data", data_out, 32'h2002);
    bubble();

    // unsigned half load, minimum latency
    drive(8'hD6, 32'h4002, 32'h0, 5'd9, 5'd0, 32'hA0);
    bus.rdata = 32'h8001_1234;
    @(negedge clk);
    bus.ack = 1'b1; #1;
    @(negedge clk);
    bus.ack = 1'b0;
    check("lhu_data", data_out, 32'h0000_8001);
    bubble();

    // misaligned accesses
    drive(8'h86, 32'h1001, 32'h0, 5'd4, 5'd0, 32'hB0);
    check("mis_ld_stall", mem_stall, 32'h0);
    @(negedge clk);
    check("mis_ld_req", bus.req, 32'h0);
    check("mis_ld_vec", vector_out, 32'd4);
    drive(8'h86, 32'h1001, 32'h0, 5'd4, 5'd2, 32'hB4);
    @(negedge clk);
    check("mis_ld_upvec", vector_out, 32'd2);
    drive(8'h18, 32'h2001, 32'h1234, 5'd0, 5'd0, 32'hB8);
    check("mis_st_stall", mem_stall, 32'h0);
    @(negedge clk);
    check("mis_st_vec", vector_out, 32'd5);
    check("mis_st_req", bus.req, 32'h0);
    bubble();

    // flush mid-access, then a normal op
    drive(8'h86, 32'h3000, 32'h0, 5'd5, 5'd0, 32'hC0);
    bus.rdata = 32'h1234_5678;
    @(negedge clk);
    mem_flush = 1'b1; #1;
    check("fl_busy_stall", mem_stall, 32'h1);
    @(negedge clk);
    mem_flush = 1'b0;
    check("fl_req_held", bus.req, 32'h1);
    bus.ack = 1'b1; #1;
    @(negedge clk);
    bus.ack = 1'b0;
    check("fl_ctrl", control_out, 32'h01);
    check("fl_data", data_out, 32'h0);
    check("fl_rd", regdst_out, 32'h0);
    drive(8'h02, 32'h55, 32'h0, 5'd6, 5'd0, 32'hC4);
    check("fl_next_stall", mem_stall, 32'h0);
    @(negedge clk);
    check("fl_next_ctrl", control_out, 32'h02);
    check("fl_next_data", data_out, 32'h55);

    // flush on the ack cycle
    drive(8'h86, 32'h3004, 32'h0, 5'd5, 5'd0, 32'hC8);
    @(negedge clk);
    bus.ack = 1'b1; mem_flush = 1'b1; #1;
    @(negedge clk);
    bus.ack = 1'b0; mem_flush = 1'b0;
    check("flack_ctrl", control_out, 32'h01);
    check("flack_req", bus.req, 32'h0);
    bubble();

    // reset in the middle of an access
    drive(8'h86, 32'h3008, 32'h0, 5'd5, 5'd0, 32'hD0);
    @(negedge clk);
    check("rstb_req_pre", bus.req, 32'h1);
    drive(8'h02, 32'h77, 32'h0, 5'd1, 5'd0, 32'hD4);
    reset = 1'b0; #1;
    check("rstb_req", bus.req, 32'h0);
    check("rstb_ctrl", control_out, 32'h01);
    check("rstb_data", data_out, 32'h0);
    bubble();
    @(negedge clk);
    reset = 1'b1;
    bus.ack = 1'b1; #1;
    check("rstb_ack_stall", mem_stall, 32'h0);
    @(negedge clk);
    bus.ack = 1'b0;
    check("rstb_ack_req", bus.req, 32'h0);
    check("rstb_ack_ctrl", control_out, 32'h01);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
